// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with dedicated PC register and write-back busy scoreboard.
// Define REGFILE_ZERO_R0_EN to hard-wire R0 to zero and exclude it from the scoreboard.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int PC_IDX   = NUM_REGS - 1,
    parameter int PC_W     = 5
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic [ADDR_W-1:0]   IR_ARn,
    input  logic [ADDR_W-1:0]   IR_ARs,
    input  logic [ADDR_W-1:0]   IR_ARm,
    input  logic [ADDR_W-1:0]   mux_ARd_or_15,
    input  logic                CNTRL_write_en_ARd,
    input  logic [DATA_W-1:0]   mux_ALU_result_or_DMEM_data,
    input  logic [PC_W-1:0]     PC_next,
    input  logic                CNTRL_pc_en,
    input  logic                CNTRL_issue_en,
    input  logic [ADDR_W-1:0]   IR_ARd_issue,
    output logic [DATA_W-1:0]   Rn,
    output logic [DATA_W-1:0]   Rs,
    output logic [DATA_W-1:0]   Rm,
    output logic [DATA_W-1:0]   Rd,
    output logic [PC_W-1:0]     PC_out,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                hazard_stall,
    output logic                issue_ready
);
`ifdef REGFILE_ZERO_R0_EN
    localparam bit ZERO_R0 = 1'b1;
`else
    localparam bit ZERO_R0 = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_d;
    logic                issue_accept;
    logic                issue_marks;

    assign hazard_stall = busy_mask[IR_ARn] | busy_mask[IR_ARs] | busy_mask[IR_ARm];
    assign issue_ready  = !hazard_stall && !busy_mask[IR_ARd_issue];
    assign issue_accept = CNTRL_issue_en && issue_ready;
    assign issue_marks  = issue_accept && IR_ARd_issue != PC_A
                          && !(ZERO_R0 && IR_ARd_issue == '0);

    // Write-back is applied after the PC update so it wins on PC_IDX; reads see mem_d.
    always_comb begin
        mem_d = mem_q;
        if (CNTRL_pc_en) mem_d[PC_IDX] = {{(DATA_W-PC_W){1'b0}}, PC_next};
        if (CNTRL_write_en_ARd) mem_d[mux_ARd_or_15] = mux_ALU_result_or_DMEM_data;
        if (ZERO_R0) mem_d[0] = '0;
    end

    // Set after clear: an issue in the same cycle as a write-back starts a new pending write.
    always_comb begin
        busy_d = busy_mask;
        if (CNTRL_write_en_ARd) busy_d[mux_ARd_or_15] = 1'b0;
        if (issue_marks) busy_d[IR_ARd_issue] = 1'b1;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
            busy_mask <= '0;
            Rn        <= '0;
            Rs        <= '0;
            Rm        <= '0;
            Rd        <= '0;
            PC_out    <= '0;
        end else begin
            mem_q     <= mem_d;
            busy_mask <= busy_d;
            Rn        <= mem_d[IR_ARn];
            Rs        <= mem_d[IR_ARs];
            Rm        <= mem_d[IR_ARm];
            Rd        <= mem_d[mux_ARd_or_15];
            PC_out    <= mem_d[PC_IDX][PC_W-1:0];
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vector table plus hand sequences for reset, R0 handling and stalls.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an, as_, am, wa, ia;
    logic        wen, pce, iss;
    logic [31:0] wd;
    logic [4:0]  pcn;
    logic [31:0] rn, rs, rm, rd;
    logic [4:0]  pc;
    logic [15:0] busy;
    logic        stall, rdy;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic        wen;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        pce;
        logic [4:0]  pcn;
        logic        iss;
        logic [3:0]  ia;
        logic [3:0]  an;
        logic [3:0]  am;
        logic        e_st;
        logic        e_rdy;
        logic [31:0] e_rn;
        logic [31:0] e_rm;
        logic [31:0] e_rd;
        logic [4:0]  e_pc;
        logic [15:0] e_busy;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    reg_file_sb dut (
        .CLOCK_50(clk), .RESET(rst),
        .IR_ARn(an), .IR_ARs(as_), .IR_ARm(am),
        .mux_ARd_or_15(wa), .CNTRL_write_en_ARd(wen), .mux_ALU_result_or_DMEM_data(wd),
        .PC_next(pcn), .CNTRL_pc_en(pce), .CNTRL_issue_en(iss), .IR_ARd_issue(ia),
        .Rn(rn), .Rs(rs), .Rm(rm), .Rd(rd), .PC_out(pc), .busy_mask(busy),
        .hazard_stall(stall), .issue_ready(rdy)
    );

    function automatic vec_t mk(input logic [31:0] w_en, w_a, w_d, p_en, p_n, i_en, i_a,
                                a_n, a_m, st, ry, x_rn, x_rm, x_rd, x_pc, x_busy);
        vec_t v;
        v.wen = w_en[0];   v.wa = w_a[3:0];  v.wd = w_d;
        v.pce = p_en[0];   v.pcn = p_n[4:0];
        v.iss = i_en[0];   v.ia = i_a[3:0];
        v.an = a_n[3:0];   v.am = a_m[3:0];
        v.e_st = st[0];    v.e_rdy = ry[0];
        v.e_rn = x_rn;     v.e_rm = x_rm;    v.e_rd = x_rd;
        v.e_pc = x_pc[4:0]; v.e_busy = x_busy[15:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wen = v.wen; wa = v.wa; wd = v.wd; pce = v.pce; pcn = v.pcn;
        iss = v.iss; ia = v.ia; an = v.an; as_ = v.an; am = v.am;
    endtask

    task automatic idle();
        wen = 0; wa = 0; wd = 0; pce = 0; pcn = 0; iss = 0; ia = 0; an = 0; as_ = 0; am = 0;
    endtask

    initial begin
        // wen wa wd | pce pcn | iss ia | an am || stall rdy | rn rm rd pc busy
        vecs[0]  = mk(1, 3, 32'hDEAD_BEEF, 0, 0, 0, 0,  3, 0, 0, 1, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0);
        vecs[1]  = mk(1, 15, 9,            1, 5, 0, 0,  3, 0, 0, 1, 32'hDEAD_BEEF, 0, 9, 9, 0);
        vecs[2]  = mk(0, 15, 0,            1, 5, 0, 0,  3, 0, 0, 1, 32'hDEAD_BEEF, 0, 5, 5, 0);
        vecs[3]  = mk(0, 4, 0,             0, 0, 1, 4,  3, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 5, 16'h0010);
        vecs[4]  = mk(0, 4, 0,             0, 0, 0, 0,  3, 4, 1, 0, 32'hDEAD_BEEF, 0, 0, 5, 16'h0010);
        vecs[5]  = mk(1, 4, 7,             0, 0, 0, 0,  3, 4, 1, 0, 32'hDEAD_BEEF, 7, 7, 5, 0);
        vecs[6]  = mk(0, 4, 0,             0, 0, 0, 0,  3, 4, 0, 1, 32'hDEAD_BEEF, 7, 7, 5, 0);
        vecs[7]  = mk(1, 6, 32'h66,        0, 0, 1, 6,  3, 4, 0, 1, 32'hDEAD_BEEF, 7, 32'h66, 5, 16'h0040);
        vecs[8]  = mk(0, 6, 0,             0, 0, 1, 8,  6, 4, 1, 0, 32'h66, 7, 32'h66, 5, 16'h0040);
        vecs[9]  = mk(0, 6, 0,             0, 0, 1, 6,  3, 4, 0, 0, 32'hDEAD_BEEF, 7, 32'h66, 5, 16'h0040);
        vecs[10] = mk(0, 15, 0,            0, 0, 1, 15, 3, 4, 0, 1, 32'hDEAD_BEEF, 7, 5, 5, 16'h0040);
        vecs[11] = mk(1, 2, 32'h22,        0, 0, 0, 0,  3, 2, 0, 1, 32'hDEAD_BEEF, 32'h22, 32'h22, 5, 16'h0040);
        vecs[12] = mk(1, 6, 32'h77,        0, 0, 0, 0,  6, 2, 1, 0, 32'h77, 32'h22, 32'h77, 5, 0);

        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;
        #1;
        chk("reset_rn", rn, 0);
        chk("reset_pc", {27'd0, pc}, 0);
        chk("reset_busy", {16'd0, busy}, 0);
        chk("reset_stall", {31'd0, stall}, 0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].e_st});
            chk($sformatf("v%0d_ready", i), {31'd0, rdy}, {31'd0, vecs[i].e_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rn", i), rn, vecs[i].e_rn);
            chk($sformatf("v%0d_rs", i), rs, vecs[i].e_rn);
            chk($sformatf("v%0d_rm", i), rm, vecs[i].e_rm);
            chk($sformatf("v%0d_rd", i), rd, vecs[i].e_rd);
            chk($sformatf("v%0d_pc", i), {27'd0, pc}, {27'd0, vecs[i].e_pc});
            chk($sformatf("v%0d_busy", i), {16'd0, busy}, {16'd0, vecs[i].e_busy});
        end

        // R0 behaviour: write R0 and issue R0 together
        @(negedge clk);
        idle();
        wen = 1; wa = 0; wd = 1; iss = 1; ia = 0;
        @(posedge clk);
        #1;
`ifdef REGFILE_ZERO_R0_EN
        chk("r0_read", rn, 0);
        chk("r0_busy", {31'd0, busy[0]}, 0);
`else
        chk("r0_read", rn, 1);
        chk("r0_busy", {31'd0, busy[0]}, 1);
`endif
        @(negedge clk);
        idle();
        #1;
`ifdef REGFILE_ZERO_R0_EN
        chk("r0_stall", {31'd0, stall}, 0);
`else
        chk("r0_stall", {31'd0, stall}, 1);
`endif
        wen = 1; wa = 0; wd = 1;
        @(posedge clk);
        #1;
        chk("r0_clear", {16'd0, busy}, 0);

        // Mid-cycle async reset with a pending busy bit and live register contents
        @(negedge clk);
        idle();
        iss = 1; ia = 5; an = 3; wa = 3;
        @(posedge clk);
        #1;
        chk("pre_rst_busy", {16'd0, busy}, 32'h20);
        chk("pre_rst_rn", rn, 32'hDEAD_BEEF);
        #2 rst = 1;
        #1;
        chk("async_rn", rn, 0);
        chk("async_rd", rd, 0);
        chk("async_pc", {27'd0, pc}, 0);
        chk("async_busy", {16'd0, busy}, 0);
        @(negedge clk);
        idle();
        an = 5;
        rst = 0;
        #1;
        chk("post_rst_stall", {31'd0, stall}, 0);
        an = 3;
        @(posedge clk);
        #1;
        chk("post_rst_mem", rn, 0);
        chk("post_rst_pc", {27'd0, pc}, 0);
        chk("post_rst_busy", {16'd0, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
